// File: rtl/hamming_counter_secded.sv
`default_nettype none
// ============================================================================
// Module   : hamming_counter_secded
// Desc     : SEC-DED protected up-counter, 4 data + 4 check bits per block,
//            with a scrub FSM. Optional statistics: HAMMING_CNT_STATS_EN.
// Revision : 1.0
// ============================================================================
module hamming_counter_secded #(
    parameter int WIDTH        = 64,
    parameter int BLOCKS       = WIDTH / 4,
    parameter int CHECK_BITS   = BLOCKS * 4,
    parameter int SCRUB_PERIOD = 256,
    parameter int STAT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        check_req,
    input  logic                        clear_err,
    input  logic                        inj_valid,
    input  logic [WIDTH+CHECK_BITS-1:0] inj_mask,
    output logic [WIDTH-1:0]            counter,
    output logic [CHECK_BITS-1:0]       check_bits,
    output logic                        count_ack,
    output logic                        wrap,
    output logic                        busy,
    output logic                        err_corrected,
    output logic                        err_fatal,
    output logic [BLOCKS-1:0]           err_block,
    output logic [STAT_W-1:0]           corr_total,
    output logic [STAT_W-1:0]           fatal_total
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_FAIL = 2'd3;

    localparam int              c_TW     = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
    localparam int              c_TMAX_I = (SCRUB_PERIOD > 0) ? SCRUB_PERIOD - 1 : 0;
    localparam logic [c_TW-1:0] c_TMAX   = c_TW'(c_TMAX_I);

    // Returns {p3, p2, p1, p0} for one data nibble.
    function automatic logic [3:0] f_encode(input logic [3:0] d);
        logic p0, p1, p2;
        p0 = d[0] ^ d[1] ^ d[3];
        p1 = d[0] ^ d[2] ^ d[3];
        p2 = d[1] ^ d[2] ^ d[3];
        return {(^d) ^ p0 ^ p1 ^ p2, p2, p1, p0};
    endfunction

    // Flip mask over {check[3:0], data[3:0]} for syndrome {overall, s[2:0]}.
    function automatic logic [7:0] f_flip(input logic [3:0] syn);
        logic [7:0] m;
        m = '0;
        if (syn[3]) begin
            case (syn[2:0])
                3'd0:    m[7] = 1'b1;
                3'd1:    m[4] = 1'b1;
                3'd2:    m[5] = 1'b1;
                3'd3:    m[0] = 1'b1;
                3'd4:    m[6] = 1'b1;
                3'd5:    m[1] = 1'b1;
                3'd6:    m[2] = 1'b1;
                default: m[3] = 1'b1;
            endcase
        end
        return m;
    endfunction

    logic [1:0]            r_state;
    logic [WIDTH-1:0]      r_cnt;
    logic [CHECK_BITS-1:0] r_chk;
    logic                  r_ack;
    logic                  r_wrap;
    logic                  r_en_last;
    logic                  r_pend;
    logic [c_TW-1:0]       r_timer;
    logic [BLOCKS-1:0]     r_err_block;
    logic [CHECK_BITS-1:0] r_syn;

    logic [CHECK_BITS-1:0] w_syn;
    logic [BLOCKS-1:0]     w_unc;
    logic [BLOCKS-1:0]     w_err;
    logic [WIDTH-1:0]      w_corr_cnt;
    logic [WIDTH-1:0]      w_inc;
    logic [CHECK_BITS-1:0] w_inc_chk;
    logic [WIDTH-1:0]      w_fix_cnt;
    logic [CHECK_BITS-1:0] w_fix_chk;
    logic [CHECK_BITS-1:0] w_clr_chk;

    assign w_inc = w_corr_cnt + WIDTH'(1);

    generate
        for (genvar i = 0; i < BLOCKS; i++) begin : g_blk
            logic [3:0] w_d;
            logic [3:0] w_c;
            logic [3:0] w_enc;
            logic [2:0] w_s;
            logic       w_o;
            logic [7:0] w_cor;
            logic [7:0] w_fix;

            assign w_d   = r_cnt[4*i +: 4];
            assign w_c   = r_chk[4*i +: 4];
            assign w_enc = f_encode(w_d);
            assign w_s   = w_enc[2:0] ^ w_c[2:0];
            assign w_o   = ^{w_c, w_d};
            assign w_cor = {w_c, w_d} ^ f_flip({w_o, w_s});
            assign w_fix = {w_c, w_d} ^ f_flip(r_syn[4*i +: 4]);

            assign w_syn[4*i +: 4]      = {w_o, w_s};
            assign w_unc[i]             = ~w_o & (|w_s);
            assign w_err[i]             = w_o | (|w_s);
            assign w_corr_cnt[4*i +: 4] = w_cor[3:0];
            assign w_fix_cnt[4*i +: 4]  = w_fix[3:0];
            assign w_fix_chk[4*i +: 4]  = w_fix[7:4];
            assign w_inc_chk[4*i +: 4]  = f_encode(w_inc[4*i +: 4]);
            assign w_clr_chk[4*i +: 4]  = w_enc;
        end
    endgenerate

    logic                  w_tmr_hit;
    logic                  w_trig_src;
    logic                  w_trig;
    logic [1:0]            w_nxt_state;
    logic [WIDTH-1:0]      w_nxt_cnt;
    logic [CHECK_BITS-1:0] w_nxt_chk;
    logic                  w_commit;
    logic                  w_nxt_pend;
    logic [c_TW-1:0]       w_nxt_timer;

    assign w_tmr_hit  = (SCRUB_PERIOD != 0) && (r_timer == c_TMAX);
    assign w_trig_src = (r_en_last & ~enable) | check_req | w_tmr_hit;
    assign w_trig     = w_trig_src | r_pend;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_chk   = r_chk;
        w_commit    = 1'b0;
        w_nxt_pend  = r_pend;
        w_nxt_timer = r_timer;
        case (r_state)
            c_IDLE: begin
                if (enable) begin
                    if (|w_unc) begin
                        w_nxt_state = c_FAIL;
                        w_nxt_pend  = 1'b0;
                    end else begin
                        w_nxt_cnt  = w_inc;
                        w_nxt_chk  = w_inc_chk;
                        w_commit   = 1'b1;
                        // A trigger colliding with an increment waits for an idle cycle.
                        w_nxt_pend = r_pend | w_trig_src;
                    end
                end else if (w_trig) begin
                    w_nxt_state = c_SCAN;
                    w_nxt_pend  = 1'b0;
                    w_nxt_timer = '0;
                end else if (SCRUB_PERIOD != 0) begin
                    w_nxt_timer = r_timer + 1'b1;
                end
            end
            c_SCAN: begin
                if (~|w_err)
                    w_nxt_state = c_IDLE;
                else if (|w_unc)
                    w_nxt_state = c_FAIL;
                else
                    w_nxt_state = c_FIX;
            end
            c_FIX: begin
                w_nxt_cnt   = w_fix_cnt;
                w_nxt_chk   = w_fix_chk;
                w_nxt_state = c_IDLE;
            end
            default: begin
                if (clear_err) begin
                    w_nxt_chk   = w_clr_chk;
                    w_nxt_state = c_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_chk       <= '0;
            r_ack       <= 1'b0;
            r_wrap      <= 1'b0;
            r_en_last   <= 1'b0;
            r_pend      <= 1'b0;
            r_timer     <= '0;
            r_err_block <= '0;
            r_syn       <= '0;
        end else begin
            r_state        <= w_nxt_state;
            {r_chk, r_cnt} <= {w_nxt_chk, w_nxt_cnt} ^ (inj_valid ? inj_mask : '0);
            r_ack          <= w_commit;
            r_wrap         <= w_commit & (&w_corr_cnt);
            r_en_last      <= enable;
            r_pend         <= w_nxt_pend;
            r_timer        <= w_nxt_timer;
            if (r_state == c_SCAN) begin
                r_err_block <= w_err;
                r_syn       <= w_syn;
            end else if ((r_state == c_FAIL) && clear_err) begin
                r_err_block <= '0;
            end
        end
    end

`ifdef HAMMING_CNT_STATS_EN
    logic [STAT_W-1:0] r_corr_total;
    logic [STAT_W-1:0] r_fatal_total;
    logic [STAT_W:0]   w_corr_sum;
    logic              w_fail_entry;

    assign w_fail_entry = (w_nxt_state == c_FAIL) && (r_state != c_FAIL);

    always_comb begin
        w_corr_sum = {1'b0, r_corr_total};
        for (int i = 0; i < BLOCKS; i++)
            w_corr_sum = w_corr_sum + (STAT_W+1)'(r_err_block[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corr_total  <= '0;
            r_fatal_total <= '0;
        end else begin
            if (r_state == c_FIX)
                r_corr_total <= w_corr_sum[STAT_W] ? '1 : w_corr_sum[STAT_W-1:0];
            if (w_fail_entry && ~&r_fatal_total)
                r_fatal_total <= r_fatal_total + 1'b1;
        end
    end

    assign corr_total  = r_corr_total;
    assign fatal_total = r_fatal_total;
`else
    assign corr_total  = '0;
    assign fatal_total = '0;
`endif

    assign counter       = r_cnt;
    assign check_bits    = r_chk;
    assign count_ack     = r_ack;
    assign wrap          = r_wrap;
    assign busy          = (r_state == c_SCAN) || (r_state == c_FIX);
    assign err_corrected = (r_state == c_FIX);
    assign err_fatal     = (r_state == c_FAIL);
    assign err_block     = r_err_block;

endmodule
`default_nettype wire

// File: tb/tb_hamming_counter_secded.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_counter_secded
// Desc     : Self-checking bench: vector table + scoreboard queue for the
//            64-bit counter, hand sequences for reset-mid-scrub and timer scrub.
// Revision : 1.0
// ============================================================================
module tb_hamming_counter_secded;

`ifdef HAMMING_CNT_STATS_EN
    localparam int c_S = 1;
`else
    localparam int c_S = 0;
`endif

    typedef struct {
        logic         en;
        logic         creq;
        logic         clr;
        logic [127:0] mask;
        logic [63:0]  cnt;
        logic [63:0]  chk;
        logic         ack;
        logic         wrap;
        logic         busy;
        logic         ecor;
        logic         efat;
        logic [15:0]  eblk;
        int           ctot;
        int           ftot;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         rst_t;
    logic         en, creq, clr, inj_v;
    logic [127:0] mask;
    logic [63:0]  counter, check_bits;
    logic         count_ack, wrap, busy, err_corrected, err_fatal;
    logic [15:0]  err_block, corr_total, fatal_total;

    logic         t_inj_v;
    logic [31:0]  t_mask;
    logic [15:0]  t_cnt, t_chk;
    logic         t_ack, t_wrap, t_busy, t_ecor, t_efat;
    logic [3:0]   t_eblk;
    logic [7:0]   t_ctot, t_ftot;

    int n_checks = 0;
    int n_errs   = 0;
    vec_t q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    hamming_counter_secded #(.WIDTH(64), .SCRUB_PERIOD(0), .STAT_W(16)) u_main (
        .clk(clk), .rst(rst), .enable(en), .check_req(creq), .clear_err(clr),
        .inj_valid(inj_v), .inj_mask(mask), .counter(counter), .check_bits(check_bits),
        .count_ack(count_ack), .wrap(wrap), .busy(busy), .err_corrected(err_corrected),
        .err_fatal(err_fatal), .err_block(err_block), .corr_total(corr_total),
        .fatal_total(fatal_total)
    );

    hamming_counter_secded #(.WIDTH(16), .SCRUB_PERIOD(4), .STAT_W(8)) u_tmr (
        .clk(clk), .rst(rst_t), .enable(1'b0), .check_req(1'b0), .clear_err(1'b0),
        .inj_valid(t_inj_v), .inj_mask(t_mask), .counter(t_cnt), .check_bits(t_chk),
        .count_ack(t_ack), .wrap(t_wrap), .busy(t_busy), .err_corrected(t_ecor),
        .err_fatal(t_efat), .err_block(t_eblk), .corr_total(t_ctot), .fatal_total(t_ftot)
    );

    function automatic logic [63:0] enc64(input logic [63:0] v);
        logic [63:0] r;
        for (int b = 0; b < 16; b++) begin
            logic [3:0] d;
            logic p0, p1, p2, p3;
            d  = v[4*b +: 4];
            p0 = d[0] ^ d[1] ^ d[3];
            p1 = d[0] ^ d[2] ^ d[3];
            p2 = d[1] ^ d[2] ^ d[3];
            p3 = d[0] ^ d[1] ^ d[2] ^ d[3] ^ p0 ^ p1 ^ p2;
            r[4*b +: 4] = {p3, p2, p1, p0};
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic en_i, creq_i, clr_i, input logic [127:0] m,
                                input logic [63:0] c, k, input logic ack, wr, bz, ec, ef,
                                input logic [15:0] eb, input int ct, ft);
        vec_t v;
        v.en = en_i; v.creq = creq_i; v.clr = clr_i; v.mask = m; v.cnt = c; v.chk = k;
        v.ack = ack; v.wrap = wr; v.busy = bz; v.ecor = ec; v.efat = ef; v.eblk = eb;
        v.ctot = ct; v.ftot = ft;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        en = v.en; creq = v.creq; clr = v.clr; inj_v = |v.mask; mask = v.mask;
        q.push_back(v);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, " counter"}, counter, e.cnt);
        chk({tag, " check_bits"}, check_bits, e.chk);
        chk({tag, " count_ack"}, count_ack, e.ack);
        chk({tag, " wrap"}, wrap, e.wrap);
        chk({tag, " busy"}, busy, e.busy);
        chk({tag, " err_corrected"}, err_corrected, e.ecor);
        chk({tag, " err_fatal"}, err_fatal, e.efat);
        chk({tag, " err_block"}, err_block, e.eblk);
        chk({tag, " corr_total"}, corr_total, 128'(e.ctot));
        chk({tag, " fatal_total"}, fatal_total, 128'(e.ftot));
        en = 0; creq = 0; clr = 0; inj_v = 0; mask = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [63:0] ones;
        int first;
        ones = '1;
        rst = 1; rst_t = 1; en = 0; creq = 0; clr = 0; inj_v = 0; mask = '0;
        t_inj_v = 0; t_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst counter", counter, 0);
        chk("rst check_bits", check_bits, 0);
        chk("rst outputs", {count_ack, wrap, busy, err_corrected, err_fatal}, 0);
        chk("rst err_block", err_block, 0);
        chk("rst totals", {corr_total, fatal_total}, 0);
        chk("rst tmr counter", {t_cnt, t_chk}, 0);
        rst = 0;

        for (int k = 1; k <= 20; k++)
            run_vec(mk(1, 0, 0, '0, 64'(k), enc64(64'(k)), 1, 0, 0, 0, 0, 0, 0, 0), "inc");
        run_vec(mk(0, 0, 0, '0, 20, enc64(20), 0, 0, 1, 0, 0, 0, 0, 0), "fall_scan");
        run_vec(mk(0, 0, 0, '0, 20, enc64(20), 0, 0, 0, 0, 0, 0, 0, 0), "fall_idle");

        // Single-bit repair of block 1 through an explicit check request.
        tbl.push_back(mk(0, 0, 0, {enc64(20) ^ enc64(10), 64'h14 ^ 64'h0A}, 64'h0A, enc64(10), 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, {64'h0, 64'h20}, 64'h2A, enc64(10), 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, '0, 64'h2A, enc64(10), 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, '0, 64'h2A, enc64(10), 0, 0, 1, 1, 0, 16'h2, 0, 0));
        tbl.push_back(mk(0, 0, 0, '0, 64'h0A, enc64(10), 0, 0, 0, 0, 0, 16'h2, c_S, 0));
        // Double-bit upset in block 3, FAIL, enable dropped, clear_err beats check_req.
        tbl.push_back(mk(0, 0, 0, {64'h0, 64'h3000}, 64'h300A, enc64(10), 0, 0, 0, 0, 0, 16'h2, c_S, 0));
        tbl.push_back(mk(0, 1, 0, '0, 64'h300A, enc64(10), 0, 0, 1, 0, 0, 16'h2, c_S, 0));
        tbl.push_back(mk(0, 0, 0, '0, 64'h300A, enc64(10), 0, 0, 0, 0, 1, 16'h8, c_S, c_S));
        tbl.push_back(mk(1, 0, 0, '0, 64'h300A, enc64(10), 0, 0, 0, 0, 1, 16'h8, c_S, c_S));
        tbl.push_back(mk(0, 1, 1, '0, 64'h300A, enc64(64'h300A), 0, 0, 0, 0, 0, 0, c_S, c_S));
        tbl.push_back(mk(0, 0, 0, '0, 64'h300A, enc64(64'h300A), 0, 0, 0, 0, 0, 0, c_S, c_S));
        // Increment from a SEC-corrected value, then clean falling-edge scrub.
        tbl.push_back(mk(0, 0, 0, {64'h0, 64'h2}, 64'h3008, enc64(64'h300A), 0, 0, 0, 0, 0, 0, c_S, c_S));
        tbl.push_back(mk(1, 0, 0, '0, 64'h300B, enc64(64'h300B), 1, 0, 0, 0, 0, 0, c_S, c_S));
        tbl.push_back(mk(0, 0, 0, '0, 64'h300B, enc64(64'h300B), 0, 0, 1, 0, 0, 0, c_S, c_S));
        tbl.push_back(mk(0, 0, 0, '0, 64'h300B, enc64(64'h300B), 0, 0, 0, 0, 0, 0, c_S, c_S));
        // All-ones preload and wrap to zero.
        tbl.push_back(mk(0, 0, 0, {enc64(64'h300B) ^ ones, 64'h300B ^ ones}, ones, ones, 0, 0, 0, 0, 0, 0, c_S, c_S));
        tbl.push_back(mk(1, 0, 0, '0, 64'h0, 64'h0, 1, 1, 0, 0, 0, 0, c_S, c_S));
        tbl.push_back(mk(0, 0, 0, '0, 64'h0, 64'h0, 0, 0, 1, 0, 0, 0, c_S, c_S));
        tbl.push_back(mk(0, 0, 0, '0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, c_S, c_S));
        // Uncorrectable seen directly by an increment request.
        tbl.push_back(mk(0, 0, 0, {64'h0, 64'h3}, 64'h3, 64'h0, 0, 0, 0, 0, 0, 0, c_S, c_S));
        tbl.push_back(mk(1, 0, 0, '0, 64'h3, 64'h0, 0, 0, 0, 0, 1, 0, c_S, 2*c_S));
        tbl.push_back(mk(0, 0, 1, '0, 64'h3, enc64(3), 0, 0, 0, 0, 0, 0, c_S, 2*c_S));
        tbl.push_back(mk(0, 0, 0, '0, 64'h3, enc64(3), 0, 0, 0, 0, 0, 0, c_S, 2*c_S));
        // Into SCAN with a correctable error, then reset lands mid-scrub.
        tbl.push_back(mk(0, 0, 0, {64'h0, 64'h1}, 64'h2, enc64(3), 0, 0, 0, 0, 0, 0, c_S, 2*c_S));
        tbl.push_back(mk(0, 1, 0, '0, 64'h2, enc64(3), 0, 0, 1, 0, 0, 0, c_S, 2*c_S));

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        rst = 1;
        #1;
        chk("midrst counter", counter, 0);
        chk("midrst check_bits", check_bits, 0);
        chk("midrst busy", busy, 0);
        chk("midrst totals", {corr_total, fatal_total}, 0);
        @(posedge clk);
        #1;
        chk("midrst held", {counter, busy, err_corrected}, 0);
        rst = 0;
        run_vec(mk(0, 0, 0, '0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst");

        // Periodic scrub on the SCRUB_PERIOD=4 instance repairs an upset p3.
        rst_t = 0;
        t_inj_v = 1; t_mask = 32'h0008_0000;
        @(posedge clk);
        #1;
        t_inj_v = 0; t_mask = '0;
        chk("tmr injected", t_chk, 16'h0008);
        first = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (t_busy && first < 0) first = c;
            if (first >= 0 && !t_busy) break;
        end
        chk("tmr scan latency", 128'(first), 128'(3));
        chk("tmr check_bits", t_chk, 16'h0);
        chk("tmr counter", t_cnt, 16'h0);
        chk("tmr err_block", t_eblk, 4'h1);
        chk("tmr corr_total", t_ctot, 128'(c_S));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_counter_secded.md
# hamming_counter_secded

Parametrised SEC-DED protected up-counter, successor to the per-nibble Hamming(7,4) counter. Each 4-bit data block carries 4 check bits (3 Hamming + 1 overall parity), so the block corrects any single-bit upset and detects any double-bit upset per block.

Increments are computed from the SEC-corrected value. A scrub state machine periodically re-checks storage and writes corrections back. An injection port and error reporting support fault-tolerance characterisation in the counter test flow.

## Interface
- WIDTH, 64, counter width; must be a multiple of 4.
- BLOCKS, WIDTH/4, number of protected 4-bit blocks (derived).
- CHECK_BITS, BLOCKS*4, stored check bits (derived).
- SCRUB_PERIOD, 256, idle cycles between automatic scrubs; 0 disables the timer.
- STAT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  increment request, level-sampled each cycle.
- check_req  in  1  one-cycle request for an immediate scrub.
- clear_err  in  1  exits FAIL; re-encodes check bits from the raw data.
- inj_valid  in  1  applies inj_mask this edge.
- inj_mask  in  WIDTH+CHECK_BITS  XOR mask over {check_bits, counter}.
- counter  out  WIDTH  raw stored data.
- check_bits  out  CHECK_BITS  raw stored check bits; block i occupies [4i+3:4i].
- count_ack  out  1  pulses on the edge an increment is committed.
- wrap  out  1  pulses when an increment takes all-ones to zero.
- busy  out  1  high in SCAN or FIX.
- err_corrected  out  1  one-cycle pulse in FIX.
- err_fatal  out  1  level, high in FAIL.
- err_block  out  BLOCKS  per-block error bitmap latched at SCAN.
- corr_total  out  STAT_W  saturating count of corrected blocks.
- fatal_total  out  STAT_W  saturating count of FAIL entries.

## Operation
- Encoding per block, data d[3:0]:
  - p0 = d0^d1^d3.
  - p1 = d0^d2^d3.
  - p2 = d1^d2^d3.
  - p3 = XOR of d[3:0] and p0..p2.
- Decode per block: s = recomputed{p2,p1,p0} ^ stored{p2,p1,p0}; o = XOR of all 8 stored bits.
  - s=0, o=0: clean.
  - o=1, s=3/5/6/7: flip d0/d1/d2/d3.
  - o=1, s=1/2/4: flip p0/p1/p2.
  - o=1, s=0: flip p3.
  - o=0, s≠0: uncorrectable.
- States: IDLE, SCAN, FIX, FAIL.
- IDLE:
  - enable=1 and no block uncorrectable (combinational decode): commit corrected+1 (mod 2^WIDTH), freshly encoded check bits, count_ack=1.
  - enable=1 and any block uncorrectable: no commit, go to FAIL.
- Scrub trigger, evaluated in IDLE only. Sources:
  - falling edge of enable (registered enable_last=1, enable=0);
  - check_req;
  - scrub timer reaching SCRUB_PERIOD-1.
  - The trigger is held pending if it coincides with a committed increment; taken on the next idle cycle with enable=0.
  - The timer counts IDLE cycles with enable=0 and resets to 0 on any scrub.
- SCAN (1 cycle): register syndromes and err_block. Next state:
  - all clean: IDLE;
  - any uncorrectable: FAIL;
  - otherwise: FIX.
- FIX (1 cycle): write corrected data and check bits for every flagged block; err_corrected=1; then IDLE.
- FAIL: enable, check_req and the timer are ignored. clear_err re-encodes check bits from the raw counter, clears err_block and returns to IDLE.
- enable in SCAN/FIX/FAIL is dropped; count_ack stays 0.
- Injection: inj_valid XORs inj_mask onto the value being written that edge (after any increment or FIX update), in any state.

## Timing
- Reset values: counter 0, check_bits 0 (a valid codeword); all other outputs 0; state IDLE; timer 0; enable_last 0; pending trigger 0.
- Increment latency: counter updates on the same edge that enable is sampled high in IDLE.
- Scrub latency: trigger visible in IDLE at edge N; SCAN at N+1; corrected data visible after edge N+2.
- busy is high exactly for the SCAN and FIX cycles.
- Reset mid-scrub: all state returns to reset values immediately; no partial writeback is retained.
- clear_err and check_req together in FAIL: clear_err wins; check_req is discarded.

## Configuration
- HAMMING_CNT_STATS_EN defined:
  - corr_total adds the number of blocks corrected in each FIX;
  - fatal_total adds 1 per FAIL entry;
  - both saturate at 2^STAT_W-1 and reset to 0.
- Undefined: corr_total and fatal_total are tied to 0. The ports remain present so the interface is unchanged.

## Test plan
- Reset, enable held 20 cycles -> counter=20, count_ack high 20 cycles, check_bits = encoding of 20, no error outputs.
- Counter at 0x00000000_0000000A, inject data bit 5, pulse check_req -> SCAN then FIX, err_block=0x0002, counter=0x0A after FIX, corr_total=1 (macro on).
- Inject two bits in block 3 data, pulse check_req -> FAIL, err_fatal=1, subsequent enable yields no count_ack; clear_err -> IDLE with check bits matching the raw counter.
- Inject one data bit, then enable for 1 cycle -> committed value = true count + 1; the falling edge of enable triggers a scrub that finds all blocks clean.
- Preload all-ones via reset-then-injection of full data mask with matching check bits, enable 1 cycle -> counter=0, wrap pulses once.
- SCRUB_PERIOD=4, idle, inject p3 of block 0 -> auto scrub within 4 cycles, check_bits bit 3 restored, counter unchanged.
